// File: rtl/btisa_seq_ctrl_if.sv
// Handshake and control-strobe bundle between the BTISA sequencer and its datapath.
// The sequencer side is the master; the decoder/memory/datapath side is the slave.
interface btisa_seq_ctrl_if;
    logic       imem_req;
    logic       imem_ready;
    logic       ir_load;
    logic       dec_reg_write;
    logic       dec_mem_read;
    logic       dec_mem_write;
    logic       dec_branch;
    logic       dec_jump;
    logic       dec_halt;
    logic       branch_taken;
    logic       dmem_req;
    logic       dmem_we;
    logic       dmem_ready;
    logic       pc_write;
    logic [1:0] pc_sel;
    logic       rf_we;
    logic       wb_sel;

    modport master (
        output imem_req, ir_load, dmem_req, dmem_we, pc_write, pc_sel, rf_we, wb_sel,
        input  imem_ready, dmem_ready, branch_taken,
        input  dec_reg_write, dec_mem_read, dec_mem_write, dec_branch, dec_jump, dec_halt
    );

    modport slave (
        input  imem_req, ir_load, dmem_req, dmem_we, pc_write, pc_sel, rf_we, wb_sel,
        output imem_ready, dmem_ready, branch_taken,
        output dec_reg_write, dec_mem_read, dec_mem_write, dec_branch, dec_jump, dec_halt
    );
endinterface

// File: rtl/btisa_seq_ctrl.sv
// Multi-cycle sequencer for the BTISA balanced-ternary CPU: steps each instruction
// through fetch/decode/execute/memory/writeback and drives the memory handshakes.
module btisa_seq_ctrl #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    btisa_seq_ctrl_if.master bus,
    output logic             halted,
    output logic             bus_error,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] instret
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5,
        HALTED = 3'd6,
        ERROR  = 3'd7
    } state_t;

    localparam int TMO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    state_t     cur_state;
    state_t     nxt_state;
    logic       f_reg_write;
    logic       f_mem_read;
    logic       f_mem_write;
    logic       f_branch;
    logic       f_jump;
    logic       f_taken;
    logic [TMO_W-1:0] tmo_cnt;
    logic       waiting;
    logic       timed_out;
    logic       retire;
    logic       active;

    // Jump outranks branch so a jump with a stale branch bit still redirects correctly.
    function automatic logic [1:0] pc_sel_f(input logic jump, input logic branch,
                                            input logic taken);
        if (jump)                return 2'b10;
        else if (branch && taken) return 2'b01;
        else                     return 2'b00;
    endfunction

    assign state     = cur_state;
    assign waiting   = ((cur_state == FETCH) && !bus.imem_ready) ||
                       ((cur_state == MEM)   && !bus.dmem_ready);
    // The counter holds completed waiting cycles, so TIMEOUT-1 means this is the last one.
    assign timed_out = (TIMEOUT != 0) && waiting && (tmo_cnt == TMO_W'(TIMEOUT - 1));
    assign active    = (cur_state == FETCH) || (cur_state == DECODE) ||
                       (cur_state == EXEC)  || (cur_state == MEM) || (cur_state == WB);

    // NOTE: every output gets a default before the case so no path can infer a latch.
    always_comb begin
        nxt_state    = cur_state;
        bus.imem_req = 1'b0;
        bus.ir_load  = 1'b0;
        bus.dmem_req = 1'b0;
        bus.dmem_we  = 1'b0;
        bus.pc_write = 1'b0;
        bus.pc_sel   = 2'b00;
        bus.rf_we    = 1'b0;
        bus.wb_sel   = 1'b0;
        halted       = 1'b0;
        bus_error    = 1'b0;
        retire       = 1'b0;
        unique case (cur_state)
            IDLE: if (run) nxt_state = FETCH;
            FETCH: begin
                bus.imem_req = 1'b1;
                bus.ir_load  = bus.imem_ready;
                if (bus.imem_ready) nxt_state = DECODE;
                else if (timed_out) nxt_state = ERROR;
            end
            DECODE: begin
                if (bus.dec_halt) begin
                    nxt_state = HALTED;
                    retire    = 1'b1;
                end else if (bus.dec_mem_read && bus.dec_mem_write) begin
                    nxt_state = ERROR;
                end else begin
                    nxt_state = EXEC;
                end
            end
            EXEC: begin
                if (f_mem_read || f_mem_write) begin
                    nxt_state = MEM;
                end else if (f_reg_write) begin
                    nxt_state = WB;
                end else begin
                    bus.pc_write = 1'b1;
                    bus.pc_sel   = pc_sel_f(f_jump, f_branch, bus.branch_taken);
                    retire       = 1'b1;
                    nxt_state    = run ? FETCH : IDLE;
                end
            end
            MEM: begin
                bus.dmem_req = 1'b1;
                bus.dmem_we  = f_mem_write;
                if (bus.dmem_ready) begin
                    if (f_mem_read) begin
                        nxt_state = WB;
                    end else begin
                        bus.pc_write = 1'b1;
                        retire       = 1'b1;
                        nxt_state    = run ? FETCH : IDLE;
                    end
                end else if (timed_out) begin
                    nxt_state = ERROR;
                end
            end
            WB: begin
                bus.rf_we    = 1'b1;
                bus.wb_sel   = f_mem_read;
                bus.pc_write = 1'b1;
                bus.pc_sel   = pc_sel_f(f_jump, f_branch, f_taken);
                retire       = 1'b1;
                nxt_state    = run ? FETCH : IDLE;
            end
            HALTED: halted    = 1'b1;
            ERROR:  bus_error = 1'b1;
            default: nxt_state = ERROR;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_state   <= IDLE;
            f_reg_write <= 1'b0;
            f_mem_read  <= 1'b0;
            f_mem_write <= 1'b0;
            f_branch    <= 1'b0;
            f_jump      <= 1'b0;
            f_taken     <= 1'b0;
            tmo_cnt     <= '0;
            cycle_count <= '0;
            instret     <= '0;
        end else begin
            cur_state <= nxt_state;
            if (cur_state == DECODE) begin
                f_reg_write <= bus.dec_reg_write;
                f_mem_read  <= bus.dec_mem_read;
                f_mem_write <= bus.dec_mem_write;
                f_branch    <= bus.dec_branch;
                f_jump      <= bus.dec_jump;
            end
            if (cur_state == EXEC) f_taken <= bus.branch_taken;
            // Any non-waiting cycle precedes entry to FETCH/MEM, so clearing here covers entry.
            tmo_cnt <= waiting ? tmo_cnt + 1'b1 : '0;
            if (active && (cycle_count != {CNT_W{1'b1}})) cycle_count <= cycle_count + 1'b1;
            if (retire && (instret != {CNT_W{1'b1}}))     instret     <= instret + 1'b1;
        end
    end

endmodule

// File: tb/tb_btisa_seq_ctrl.sv
// Directed bench for btisa_seq_ctrl: expected per-cycle outputs go through a scoreboard
// queue and are compared at the falling edge against the DUT.
module tb_btisa_seq_ctrl;

    localparam int CNT_W = 16;

    typedef struct packed {
        logic [2:0] st;
        logic       imem_req;
        logic       ir_load;
        logic       dmem_req;
        logic       dmem_we;
        logic       pc_write;
        logic [1:0] pc_sel;
        logic       rf_we;
        logic       wb_sel;
        logic       halted;
        logic       bus_error;
    } obs_t;

    logic             clk;
    logic             rst;
    logic             run;
    logic             halted;
    logic             bus_error;
    logic [2:0]       state;
    logic [CNT_W-1:0] cycle_count;
    logic [CNT_W-1:0] instret;

    btisa_seq_ctrl_if bus ();

    btisa_seq_ctrl #(.CNT_W(CNT_W), .TIMEOUT(15)) dut (
        .clk         (clk),
        .rst         (rst),
        .run         (run),
        .bus         (bus),
        .halted      (halted),
        .bus_error   (bus_error),
        .state       (state),
        .cycle_count (cycle_count),
        .instret     (instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    obs_t             sb[$];
    int               n_vec;
    int               n_err;
    logic [CNT_W-1:0] exp_cyc;
    logic [CNT_W-1:0] exp_ret;

    function automatic obs_t ex(input logic [2:0] st, input logic imr, input logic irl,
                                input logic dr, input logic dwe, input logic pcw,
                                input logic [1:0] sel, input logic rfwe, input logic wbs);
        obs_t o;
        o.st = st; o.imem_req = imr; o.ir_load = irl; o.dmem_req = dr; o.dmem_we = dwe;
        o.pc_write = pcw; o.pc_sel = sel; o.rf_we = rfwe; o.wb_sel = wbs;
        o.halted = (st == 3'd6);
        o.bus_error = (st == 3'd7);
        return o;
    endfunction

    function automatic obs_t e_idle();                      return ex(3'd0, 0, 0, 0, 0, 0, 2'b00, 0, 0); endfunction
    function automatic obs_t e_fetch(input logic irl);      return ex(3'd1, 1, irl, 0, 0, 0, 2'b00, 0, 0); endfunction
    function automatic obs_t e_dec();                       return ex(3'd2, 0, 0, 0, 0, 0, 2'b00, 0, 0); endfunction
    function automatic obs_t e_exec(input logic pcw, input logic [1:0] sel);
        return ex(3'd3, 0, 0, 0, 0, pcw, sel, 0, 0);
    endfunction
    function automatic obs_t e_mem(input logic we, input logic pcw);
        return ex(3'd4, 0, 0, 1, we, pcw, 2'b00, 0, 0);
    endfunction
    function automatic obs_t e_wb(input logic wbs, input logic [1:0] sel);
        return ex(3'd5, 0, 0, 0, 0, 1, sel, 1, wbs);
    endfunction
    function automatic obs_t e_halt();                      return ex(3'd6, 0, 0, 0, 0, 0, 2'b00, 0, 0); endfunction
    function automatic obs_t e_err();                       return ex(3'd7, 0, 0, 0, 0, 0, 2'b00, 0, 0); endfunction

    function automatic obs_t sample();
        obs_t o;
        o.st = state; o.imem_req = bus.imem_req; o.ir_load = bus.ir_load;
        o.dmem_req = bus.dmem_req; o.dmem_we = bus.dmem_we; o.pc_write = bus.pc_write;
        o.pc_sel = bus.pc_sel; o.rf_we = bus.rf_we; o.wb_sel = bus.wb_sel;
        o.halted = halted; o.bus_error = bus_error;
        return o;
    endfunction

    // One clock cycle: queue the expectation, compare mid-cycle, advance past the edge.
    task automatic step(input string tag, input obs_t e);
        obs_t got;
        obs_t want;
        sb.push_back(e);
        @(negedge clk);
        got  = sample();
        want = sb.pop_front();
        n_vec++;
        assert (got === want) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, want);
        end
        if (want.st inside {3'd1, 3'd2, 3'd3, 3'd4, 3'd5}) exp_cyc++;
        if (want.pc_write) exp_ret++;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_cnt(input string tag);
        n_vec++;
        assert ({cycle_count, instret} === {exp_cyc, exp_ret}) else begin
            n_err++;
            $error("FAIL %s: observed cyc=%0d ret=%0d expected cyc=%0d ret=%0d",
                   tag, cycle_count, instret, exp_cyc, exp_ret);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_cyc = '0;
        exp_ret = '0;
    endtask

    task automatic clr_dec();
        bus.dec_reg_write = 1'b0; bus.dec_mem_read = 1'b0; bus.dec_mem_write = 1'b0;
        bus.dec_branch = 1'b0; bus.dec_jump = 1'b0; bus.dec_halt = 1'b0;
    endtask

    initial begin
        n_vec = 0; n_err = 0; exp_cyc = '0; exp_ret = '0;
        rst = 1'b1; run = 1'b0;
        bus.imem_ready = 1'b0; bus.dmem_ready = 1'b0; bus.branch_taken = 1'b0;
        clr_dec();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_cnt("reset_cnt");
        step("reset_idle", e_idle());

        // ALU op, zero-wait: F, D, E, WB.
        run = 1'b1; bus.imem_ready = 1'b1; bus.dec_reg_write = 1'b1;
        step("alu_idle", e_idle());
        step("alu_fetch", e_fetch(1'b1));
        step("alu_dec", e_dec());
        step("alu_exec", e_exec(1'b0, 2'b00));
        run = 1'b0;
        step("alu_wb", e_wb(1'b0, 2'b00));
        n_vec++;
        assert ({cycle_count, instret} === {16'd4, 16'd1}) else begin
            n_err++;
            $error("FAIL alu_cnt: observed cyc=%0d ret=%0d expected cyc=4 ret=1", cycle_count, instret);
        end
        step("alu_to_idle", e_idle());

        // Load with a 3-cycle data memory, then a zero-wait store.
        run = 1'b1; bus.dec_mem_read = 1'b1;
        step("ld_idle", e_idle());
        step("ld_fetch", e_fetch(1'b1));
        step("ld_dec", e_dec());
        step("ld_exec", e_exec(1'b0, 2'b00));
        step("ld_mem1", e_mem(1'b0, 1'b0));
        step("ld_mem2", e_mem(1'b0, 1'b0));
        bus.dmem_ready = 1'b1;
        step("ld_mem3", e_mem(1'b0, 1'b0));
        bus.dmem_ready = 1'b0;
        step("ld_wb", e_wb(1'b1, 2'b00));
        clr_dec(); bus.dec_mem_write = 1'b1;
        step("st_fetch", e_fetch(1'b1));
        step("st_dec", e_dec());
        step("st_exec", e_exec(1'b0, 2'b00));
        bus.dmem_ready = 1'b1;
        step("st_mem", e_mem(1'b1, 1'b1));
        bus.dmem_ready = 1'b0;

        // Control flow: taken/not-taken branch, JAL, branch+jump.
        clr_dec(); bus.dec_branch = 1'b1;
        step("bt_fetch", e_fetch(1'b1));
        step("bt_dec", e_dec());
        bus.branch_taken = 1'b1;
        step("bt_exec", e_exec(1'b1, 2'b01));
        step("bn_fetch", e_fetch(1'b1));
        step("bn_dec", e_dec());
        bus.branch_taken = 1'b0;
        step("bn_exec", e_exec(1'b1, 2'b00));
        clr_dec(); bus.dec_jump = 1'b1; bus.dec_reg_write = 1'b1;
        step("jal_fetch", e_fetch(1'b1));
        step("jal_dec", e_dec());
        step("jal_exec", e_exec(1'b0, 2'b00));
        step("jal_wb", e_wb(1'b0, 2'b10));
        clr_dec(); bus.dec_jump = 1'b1; bus.dec_branch = 1'b1;
        step("bj_fetch", e_fetch(1'b1));
        step("bj_dec", e_dec());
        bus.branch_taken = 1'b1; run = 1'b0;
        step("bj_exec", e_exec(1'b1, 2'b10));
        bus.branch_taken = 1'b0; clr_dec();
        chk_cnt("ctrl_cnt");
        step("ctrl_idle", e_idle());

        // Fetch timeout: 15 cycles without imem_ready lands in ERROR.
        do_reset();
        chk_cnt("tmo_rst_cnt");
        run = 1'b1; bus.imem_ready = 1'b0;
        step("tmo_idle", e_idle());
        for (int i = 0; i < 15; i++) step("tmo_fetch", e_fetch(1'b0));
        step("tmo_err", e_err());
        run = 1'b0;
        step("tmo_err_run0", e_err());
        run = 1'b1;
        step("tmo_err_run1", e_err());
        chk_cnt("tmo_cnt_frozen");
        do_reset();
        chk_cnt("tmo_clr_cnt");
        step("tmo_clr_idle", e_idle());

        // Ready on the 15th waiting cycle is accepted.
        for (int i = 0; i < 14; i++) step("edge_fetch", e_fetch(1'b0));
        bus.imem_ready = 1'b1; bus.dec_branch = 1'b1;
        step("edge_fetch15", e_fetch(1'b1));
        step("edge_dec", e_dec());
        run = 1'b0;
        step("edge_exec", e_exec(1'b1, 2'b00));
        step("edge_idle", e_idle());
        chk_cnt("edge_cnt");

        // Halt: retires, then everything freezes regardless of run.
        do_reset();
        clr_dec(); bus.dec_halt = 1'b1; run = 1'b1;
        step("hlt_idle", e_idle());
        step("hlt_fetch", e_fetch(1'b1));
        step("hlt_dec", e_dec());
        exp_ret++;
        for (int i = 0; i < 20; i++) begin
            run = i[0];
            step("hlt_hold", e_halt());
        end
        chk_cnt("hlt_cnt");

        // Illegal control: read and write together.
        do_reset();
        clr_dec(); bus.dec_mem_read = 1'b1; bus.dec_mem_write = 1'b1; run = 1'b1;
        step("ill_idle", e_idle());
        step("ill_fetch", e_fetch(1'b1));
        step("ill_dec", e_dec());
        step("ill_err", e_err());
        step("ill_err_hold", e_err());
        chk_cnt("ill_cnt");

        // run dropped during a load's MEM: the load completes, then IDLE.
        do_reset();
        clr_dec(); bus.dec_mem_read = 1'b1; bus.dec_reg_write = 1'b1; run = 1'b1;
        step("pause_idle", e_idle());
        step("pause_fetch", e_fetch(1'b1));
        step("pause_dec", e_dec());
        step("pause_exec", e_exec(1'b0, 2'b00));
        run = 1'b0;
        step("pause_mem1", e_mem(1'b0, 1'b0));
        bus.dmem_ready = 1'b1;
        step("pause_mem2", e_mem(1'b0, 1'b0));
        bus.dmem_ready = 1'b0;
        step("pause_wb", e_wb(1'b1, 2'b00));
        step("pause_to_idle", e_idle());
        chk_cnt("pause_cnt");

        // Reset in the middle of MEM drops dmem_req and clears counters.
        run = 1'b1;
        step("rmid_idle", e_idle());
        step("rmid_fetch", e_fetch(1'b1));
        step("rmid_dec", e_dec());
        step("rmid_exec", e_exec(1'b0, 2'b00));
        step("rmid_mem", e_mem(1'b0, 1'b0));
        run = 1'b0;
        do_reset();
        chk_cnt("rmid_cnt");
        step("rmid_after", e_idle());

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
